// File: rtl/mcalu_rsv_station.sv
// Age-ordered, collapsing reservation station issuing to the multi-cycle ALU.
// Optional macro MCALU_RS_BYPASS_EN: entries woken by the current writeback may issue in that cycle.
module mcalu_rsv_station #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        disp_valid,
   input  logic [4:0]  disp_op,
   input  logic [6:0]  disp_robid,
   input  logic [5:0]  disp_rd,
   input  logic        disp_op1_rdy,
   input  logic [31:0] disp_op1,
   input  logic        disp_op2_rdy,
   input  logic [31:0] disp_op2,
   output logic        exers_stall,
   input  logic        wb_valid,
   input  logic [6:0]  wb_robid,
   input  logic [31:0] wb_result,
   output logic        exers_mcalu_issue,
   output logic [4:0]  exers_mcalu_op,
   output logic [6:0]  exers_robid,
   output logic [5:0]  exers_rd,
   output logic [31:0] exers_op1,
   output logic [31:0] exers_op2,
   input  logic        mcalu_stall,
   input  logic        rob_flush
);

   typedef struct packed {
      logic        vld;
      logic [4:0]  op;
      logic [6:0]  robid;
      logic [5:0]  rd;
      logic        r1;
      logic [31:0] v1;
      logic        r2;
      logic [31:0] v2;
   } ent_t;

   ent_t             ent_q [DEPTH];
   ent_t             ent_d [DEPTH];
   ent_t             ext_s [DEPTH+1];
   ent_t             disp_e_s;
   logic [DEPTH-1:0] vld_s;
   logic [DEPTH-1:0] rdy_s;
   logic [DEPTH-1:0] sel_s;
   logic [DEPTH-1:0] ge_s;
   logic [DEPTH-1:0] shift_s;
   logic [DEPTH:0]   wk1_s;
   logic [DEPTH:0]   wk2_s;
   logic             issue_s;
   logic             fire_s;
   logic             accept_s;
   logic             disp_m1_s;
   logic             disp_m2_s;

   // Per-entry wakeup match against the broadcast and readiness from state.
   always_comb begin
      wk1_s = '0;
      wk2_s = '0;
      vld_s = '0;
      rdy_s = '0;
      for (int i = 0; i < DEPTH; i++) begin
         vld_s[i] = ent_q[i].vld;
         wk1_s[i] = wb_valid & ent_q[i].vld & ~ent_q[i].r1 & (ent_q[i].v1[6:0] == wb_robid);
         wk2_s[i] = wb_valid & ent_q[i].vld & ~ent_q[i].r2 & (ent_q[i].v2[6:0] == wb_robid);
`ifdef MCALU_RS_BYPASS_EN
         rdy_s[i] = ent_q[i].vld & (ent_q[i].r1 | wk1_s[i]) & (ent_q[i].r2 | wk2_s[i]);
`else
         rdy_s[i] = ent_q[i].vld & ent_q[i].r1 & ent_q[i].r2;
`endif
      end
   end

   // Oldest-ready select; ge_s marks every slot at or above the selected one.
   always_comb begin
      logic acc;
      acc   = 1'b0;
      sel_s = '0;
      ge_s  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         sel_s[i] = rdy_s[i] & ~acc;
         acc      = acc | rdy_s[i];
         ge_s[i]  = acc;
      end
   end

   assign issue_s     = |rdy_s;
   assign exers_stall = &vld_s;
   assign fire_s      = issue_s & ~mcalu_stall;
   assign accept_s    = disp_valid & ~exers_stall & ~rob_flush;
   assign shift_s     = ge_s & {DEPTH{fire_s}};

   // Offer bus: AND-OR mux of the selected entry, zero when nothing is offered.
   always_comb begin
      exers_mcalu_issue = issue_s;
      exers_mcalu_op    = 5'h00;
      exers_robid       = 7'h00;
      exers_rd          = 6'h00;
      exers_op1         = 32'h0000_0000;
      exers_op2         = 32'h0000_0000;
      for (int i = 0; i < DEPTH; i++) begin
         exers_mcalu_op = exers_mcalu_op | (ent_q[i].op    & {5{sel_s[i]}});
         exers_robid    = exers_robid    | (ent_q[i].robid & {7{sel_s[i]}});
         exers_rd       = exers_rd       | (ent_q[i].rd    & {6{sel_s[i]}});
`ifdef MCALU_RS_BYPASS_EN
         exers_op1 = exers_op1 | ((wk1_s[i] ? wb_result : ent_q[i].v1) & {32{sel_s[i]}});
         exers_op2 = exers_op2 | ((wk2_s[i] ? wb_result : ent_q[i].v2) & {32{sel_s[i]}});
`else
         exers_op1 = exers_op1 | (ent_q[i].v1 & {32{sel_s[i]}});
         exers_op2 = exers_op2 | (ent_q[i].v2 & {32{sel_s[i]}});
`endif
      end
   end

   // Incoming entry, pre-woken if its tag matches this cycle's broadcast.
   always_comb begin
      disp_m1_s      = wb_valid & ~disp_op1_rdy & (disp_op1[6:0] == wb_robid);
      disp_m2_s      = wb_valid & ~disp_op2_rdy & (disp_op2[6:0] == wb_robid);
      disp_e_s.vld   = 1'b1;
      disp_e_s.op    = disp_op;
      disp_e_s.robid = disp_robid;
      disp_e_s.rd    = disp_rd;
      disp_e_s.r1    = disp_op1_rdy | disp_m1_s;
      disp_e_s.v1    = disp_m1_s ? wb_result : disp_op1;
      disp_e_s.r2    = disp_op2_rdy | disp_m2_s;
      disp_e_s.v2    = disp_m2_s ? wb_result : disp_op2;
   end

   // Next state: collapse over the issued slot, wake at new position, append dispatch.
   always_comb begin
      logic placed;
      logic w1;
      logic w2;
      logic take;
      placed = 1'b0;
      w1     = 1'b0;
      w2     = 1'b0;
      take   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         ext_s[i] = ent_q[i];
      end
      ext_s[DEPTH] = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (shift_s[i]) begin
            ent_d[i] = ext_s[i+1];
            w1       = wk1_s[i+1];
            w2       = wk2_s[i+1];
         end else begin
            ent_d[i] = ext_s[i];
            w1       = wk1_s[i];
            w2       = wk2_s[i];
         end
         ent_d[i].r1 = ent_d[i].r1 | w1;
         ent_d[i].v1 = w1 ? wb_result : ent_d[i].v1;
         ent_d[i].r2 = ent_d[i].r2 | w2;
         ent_d[i].v2 = w2 ? wb_result : ent_d[i].v2;
         take        = accept_s & ~placed & ~ent_d[i].vld;
         ent_d[i]    = take ? disp_e_s : ent_d[i];
         placed      = placed | take;
      end
   end

   // Entry storage; reset and flush empty the station.
   always_ff @(posedge clk) begin
      if (rst || rob_flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
         end
      end
   end

endmodule

// File: tb/tb_mcalu_rsv_station.sv
// Directed bench for mcalu_rsv_station; honours MCALU_RS_BYPASS_EN when defined.
module tb_mcalu_rsv_station;

   logic        clk;
   logic        rst;
   logic        disp_valid;
   logic [4:0]  disp_op;
   logic [6:0]  disp_robid;
   logic [5:0]  disp_rd;
   logic        disp_op1_rdy;
   logic [31:0] disp_op1;
   logic        disp_op2_rdy;
   logic [31:0] disp_op2;
   logic        exers_stall;
   logic        wb_valid;
   logic [6:0]  wb_robid;
   logic [31:0] wb_result;
   logic        exers_mcalu_issue;
   logic [4:0]  exers_mcalu_op;
   logic [6:0]  exers_robid;
   logic [5:0]  exers_rd;
   logic [31:0] exers_op1;
   logic [31:0] exers_op2;
   logic        mcalu_stall;
   logic        rob_flush;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   mcalu_rsv_station #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .disp_valid(disp_valid), .disp_op(disp_op), .disp_robid(disp_robid), .disp_rd(disp_rd),
      .disp_op1_rdy(disp_op1_rdy), .disp_op1(disp_op1),
      .disp_op2_rdy(disp_op2_rdy), .disp_op2(disp_op2),
      .exers_stall(exers_stall),
      .wb_valid(wb_valid), .wb_robid(wb_robid), .wb_result(wb_result),
      .exers_mcalu_issue(exers_mcalu_issue), .exers_mcalu_op(exers_mcalu_op),
      .exers_robid(exers_robid), .exers_rd(exers_rd),
      .exers_op1(exers_op1), .exers_op2(exers_op2),
      .mcalu_stall(mcalu_stall), .rob_flush(rob_flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic disp(input logic [6:0] robid, input logic [4:0] op,
                       input logic r1, input logic [31:0] v1,
                       input logic r2, input logic [31:0] v2);
      disp_valid   = 1'b1;
      disp_op      = op;
      disp_robid   = robid;
      disp_rd      = robid[5:0];
      disp_op1_rdy = r1;
      disp_op1     = v1;
      disp_op2_rdy = r2;
      disp_op2     = v2;
   endtask

   task automatic no_disp();
      disp_valid   = 1'b0;
      disp_op      = 5'h00;
      disp_robid   = 7'h00;
      disp_rd      = 6'h00;
      disp_op1_rdy = 1'b0;
      disp_op1     = 32'h0;
      disp_op2_rdy = 1'b0;
      disp_op2     = 32'h0;
   endtask

   task automatic wb(input logic v, input logic [6:0] tag, input logic [31:0] res);
      wb_valid  = v;
      wb_robid  = tag;
      wb_result = res;
   endtask

   initial begin
      rst = 1'b1;
      mcalu_stall = 1'b0;
      rob_flush = 1'b0;
      no_disp();
      wb(1'b0, 7'h00, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_issue", {31'h0, exers_mcalu_issue}, 32'h0);
      chk("rst_stall", {31'h0, exers_stall}, 32'h0);
      chk("rst_op1", exers_op1, 32'h0);
      chk("rst_op2", exers_op2, 32'h0);
      chk("rst_robid", {25'h0, exers_robid}, 32'h0);

      // Simple ready op: offered next cycle, removed on accept.
      disp(7'h0A, 5'h00, 1'b1, 32'd3, 1'b1, 32'd4);
      tick();
      no_disp();
      #1;
      chk("add_issue", {31'h0, exers_mcalu_issue}, 32'h1);
      chk("add_op1", exers_op1, 32'd3);
      chk("add_op2", exers_op2, 32'd4);
      chk("add_robid", {25'h0, exers_robid}, 32'h0A);
      chk("add_rd", {26'h0, exers_rd}, 32'h0A);
      tick();
      chk("add_gone", {31'h0, exers_mcalu_issue}, 32'h0);
      chk("add_gone_op1", exers_op1, 32'h0);

      // Wakeup from writeback broadcast.
      disp(7'h14, 5'h10, 1'b0, 32'h12, 1'b1, 32'd9);
      tick();
      no_disp();
      #1;
      chk("wk_wait", {31'h0, exers_mcalu_issue}, 32'h0);
      wb(1'b1, 7'h12, 32'hDEAD);
      #1;
`ifdef MCALU_RS_BYPASS_EN
      chk("wk_byp_issue", {31'h0, exers_mcalu_issue}, 32'h1);
      chk("wk_byp_op1", exers_op1, 32'hDEAD);
      chk("wk_byp_op2", exers_op2, 32'd9);
      tick();
      wb(1'b0, 7'h00, 32'h0);
      #1;
      chk("wk_byp_gone", {31'h0, exers_mcalu_issue}, 32'h0);
`else
      chk("wk_same_cyc", {31'h0, exers_mcalu_issue}, 32'h0);
      tick();
      wb(1'b0, 7'h00, 32'h0);
      #1;
      chk("wk_issue", {31'h0, exers_mcalu_issue}, 32'h1);
      chk("wk_op1", exers_op1, 32'hDEAD);
      chk("wk_op2", exers_op2, 32'd9);
      chk("wk_op", {27'h0, exers_mcalu_op}, 32'h10);
      tick();
      chk("wk_gone", {31'h0, exers_mcalu_issue}, 32'h0);
`endif

      // Fill to full under mcalu_stall, then drain in order.
      mcalu_stall = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         disp(7'(i), 5'h01, 1'b1, 32'(100 + i), 1'b1, 32'(i));
         tick();
      end
      disp(7'h05, 5'h01, 1'b1, 32'd105, 1'b1, 32'd5);
      #1;
      chk("full_stall", {31'h0, exers_stall}, 32'h1);
      chk("full_held", {25'h0, exers_robid}, 32'h1);
      tick();
      mcalu_stall = 1'b0;
      #1;
      chk("full_stall2", {31'h0, exers_stall}, 32'h1);
      chk("full_held2", {25'h0, exers_robid}, 32'h1);
      chk("full_op1", exers_op1, 32'd101);
      tick();
      no_disp();
      #1;
      chk("drain_stall", {31'h0, exers_stall}, 32'h0);
      chk("drain_2", {25'h0, exers_robid}, 32'h2);
      tick();
      chk("drain_3", {25'h0, exers_robid}, 32'h3);
      tick();
      chk("drain_4", {25'h0, exers_robid}, 32'h4);
      chk("drain_4_op2", exers_op2, 32'h4);
      tick();
      chk("drain_empty", {31'h0, exers_mcalu_issue}, 32'h0);

      // Older waiting entry is bypassed by a younger ready one.
      mcalu_stall = 1'b1;
      disp(7'h01, 5'h02, 1'b0, 32'h30, 1'b1, 32'd11);
      tick();
      disp(7'h02, 5'h03, 1'b1, 32'd21, 1'b1, 32'd22);
      tick();
      no_disp();
      mcalu_stall = 1'b0;
      #1;
      chk("ooo_first", {25'h0, exers_robid}, 32'h2);
      tick();
      chk("ooo_wait", {31'h0, exers_mcalu_issue}, 32'h0);
      wb(1'b1, 7'h30, 32'h1234_5678);
      #1;
`ifdef MCALU_RS_BYPASS_EN
      chk("ooo_byp_robid", {25'h0, exers_robid}, 32'h1);
      chk("ooo_byp_op1", exers_op1, 32'h1234_5678);
      tick();
      wb(1'b0, 7'h00, 32'h0);
`else
      tick();
      wb(1'b0, 7'h00, 32'h0);
      #1;
      chk("ooo_robid", {25'h0, exers_robid}, 32'h1);
      chk("ooo_op1", exers_op1, 32'h1234_5678);
      tick();
`endif
      chk("ooo_empty", {31'h0, exers_mcalu_issue}, 32'h0);

      // Combined edge: issue+collapse, wakeup of collapsed entry, same-cycle tag dispatch.
      mcalu_stall = 1'b1;
      disp(7'h28, 5'h04, 1'b1, 32'd1, 1'b1, 32'd2);
      tick();
      disp(7'h29, 5'h05, 1'b0, 32'h31, 1'b1, 32'd3);
      tick();
      mcalu_stall = 1'b0;
      disp(7'h2A, 5'h06, 1'b1, 32'd7, 1'b0, 32'h31);
      wb(1'b1, 7'h31, 32'hCAFE_F00D);
      #1;
      chk("cmb_first", {25'h0, exers_robid}, 32'h28);
      tick();
      no_disp();
      wb(1'b0, 7'h00, 32'h0);
      #1;
      chk("cmb_second", {25'h0, exers_robid}, 32'h29);
      chk("cmb_second_op1", exers_op1, 32'hCAFE_F00D);
      tick();
      chk("cmb_third", {25'h0, exers_robid}, 32'h2A);
      chk("cmb_third_op1", exers_op1, 32'd7);
      chk("cmb_third_op2", exers_op2, 32'hCAFE_F00D);
      tick();
      chk("cmb_empty", {31'h0, exers_mcalu_issue}, 32'h0);

      // Flush with three entries and a dispatch in the same cycle.
      mcalu_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         disp(7'(8'h32 + i), 5'h07, 1'b1, 32'(i), 1'b1, 32'(i));
         tick();
      end
      disp(7'h35, 5'h07, 1'b1, 32'd9, 1'b1, 32'd9);
      rob_flush = 1'b1;
      #1;
      chk("fl_pre_issue", {31'h0, exers_mcalu_issue}, 32'h1);
      tick();
      rob_flush = 1'b0;
      no_disp();
      #1;
      chk("fl_issue", {31'h0, exers_mcalu_issue}, 32'h0);
      chk("fl_stall", {31'h0, exers_stall}, 32'h0);
      chk("fl_op1", exers_op1, 32'h0);
      tick();
      chk("fl_still_empty", {31'h0, exers_mcalu_issue}, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
